muldiv_ctrl: RTL and testbench

- Sequencing controller for the CPU's multiply/divide resource; owns the HI/LO registers.
- Issues single-cycle MULT/MULTU/MTHI/MTLO writes to HI/LO.
- Runs a 32-iteration shift-subtract engine shared by DIV and DIVU, and raises stall so the PC holds while a division is in flight.
- Sits beside the ALU and decode; stall feeds the PC register enable, hi/lo feed the MFHI/MFLO write-back mux.

---
 rtl/muldiv_ctrl.sv | 179 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multiply/divide sequencer that owns the HI/LO registers.
// MULT/MULTU/MTHI/MTLO complete in a single cycle. DIV/DIVU run a
// restoring shift-subtract engine that produces one quotient bit per cycle.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   op_valid, op    decoded operation targeting this block
//   rs, rt          register operands
//   stall           combinational PC hold while a divide is accepted or running
//   busy            registered, high while the divide engine is running
//   done            registered pulse in the cycle a division completes
//   div_by_zero     registered pulse alongside done when the divisor was zero
//   hi, lo          HI/LO architectural registers
module muldiv_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(ITER);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             accept_div;
    logic             is_sdiv;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_nx, quot_nx;
    logic [2*WIDTH-1:0] prod_s, prod_u;

    // Both products are taken modulo 2^(2*WIDTH); sign extension yields the signed result.
    assign prod_s = {{WIDTH{rs[WIDTH-1]}}, rs} * {{WIDTH{rt[WIDTH-1]}}, rt};
    assign prod_u = {{WIDTH{1'b0}}, rs} * {{WIDTH{1'b0}}, rt};

    assign accept_div = (state_q == S_IDLE) && op_valid && ((op == OP_DIV) || (op == OP_DIVU));
    assign stall      = accept_div || (state_q == S_RUN);

    // Operand magnitudes; |0x80000000| stays 0x80000000 as an unsigned value.
    assign is_sdiv = (op == OP_DIV);
    assign rs_mag  = (is_sdiv && rs[WIDTH-1]) ? -rs : rs;
    assign rt_mag  = (is_sdiv && rt[WIDTH-1]) ? -rt : rt;

    // One restoring step on {rem, quot}; the shifted remainder needs one extra bit.
    assign rem_sh  = {rem_q, quot_q[WIDTH-1]};
    assign rem_ge  = rem_sh >= {1'b0, dvsr_q};
    assign rem_sub = rem_sh[WIDTH-1:0] - dvsr_q;
    assign rem_nx  = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
    assign quot_nx = {quot_q[WIDTH-2:0], rem_ge};

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_MTHI:  hi_d = rs;
                        OP_MTLO:  lo_d = rs;
                        OP_DIV, OP_DIVU: begin
                            dvsr_d  = rt_mag;
                            quot_d  = rs_mag;
                            rem_d   = '0;
                            cnt_d   = '0;
                            q_neg_d = is_sdiv && (rs[WIDTH-1] ^ rt[WIDTH-1]);
                            r_neg_d = is_sdiv && rs[WIDTH-1];
                            if (rt == '0) begin
                                state_d = S_FINISH;
                                dbz_d   = 1'b1;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                rem_d  = rem_nx;
                quot_d = quot_nx;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    lo_d    = q_neg_q ? -quot_nx : quot_nx;
                    hi_d    = r_neg_q ? -rem_nx : rem_nx;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_FINISH);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvsr_q  <= dvsr_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a reference model feeding a scoreboard queue.
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        stall;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] exp_q[$];

    muldiv_ctrl #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs(rs), .rt(rt),
        .stall(stall), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expected {hi,lo} and compare against the DUT.
    task automatic sb_check(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, {hi, lo});
        end else begin
            e = exp_q.pop_front();
            chk(tag, {hi, lo}, e);
        end
    endtask

    // Reference model for the single-cycle ops.
    task automatic model_simple(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic signed [63:0] ea, eb, p;
        sa = a; sb = b; ea = sa; eb = sb;
        case (o)
            3'b000: begin p = ea * eb; {m_hi, m_lo} = p; end
            3'b001: {m_hi, m_lo} = {32'h0, a} * {32'h0, b};
            3'b100: m_hi = a;
            3'b101: m_lo = a;
            default: ;
        endcase
    endtask

    // Reference model for division; remainder follows dividend, quotient truncates to zero.
    task automatic model_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        if (b == 32'h0) begin
            // hi/lo unchanged
        end else if (o == 3'b011) begin
            m_lo = a / b;
            m_hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_lo = 32'h8000_0000;
            m_hi = 32'h0;
        end else begin
            sa = a; sb = b;
            sq = sa / sb;
            sr = sa % sb;
            m_lo = sq;
            m_hi = sr;
        end
    endtask

    // Single-cycle op: no stall, result visible after one edge.
    task automatic do_simple(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1; op = o; rs = a; rt = b;
        model_simple(o, a, b);
        exp_q.push_back({m_hi, m_lo});
        #1;
        chk({tag, "_stall"}, 64'(stall), 64'(0));
        step();
        sb_check(tag);
    endtask

    // Division held until stall drops; counts stall and busy cycles.
    task automatic do_div(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int n_stall, n_busy;
        logic zero;
        zero = (b == 32'h0);
        op_valid = 1'b1; op = o; rs = a; rt = b;
        model_div(o, a, b);
        exp_q.push_back({m_hi, m_lo});
        n_stall = 0; n_busy = 0;
        #1;
        while (stall === 1'b1 && n_stall < 100) begin
            n_stall++;
            step();
            if (busy === 1'b1) n_busy++;
        end
        #1;
        chk({tag, "_stall_cycles"}, 64'(n_stall), zero ? 64'(1) : 64'(33));
        chk({tag, "_busy_cycles"}, 64'(n_busy), zero ? 64'(0) : 64'(32));
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(zero));
        sb_check(tag);
        op_valid = 1'b0;
        step();
        chk({tag, "_done_clr"}, 64'(done), 64'(0));
        chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op = 3'b000; rs = '0; rt = '0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("reset_hilo", {hi, lo}, 64'h0);
        chk("reset_flags", {61'h0, busy, done, div_by_zero}, 64'h0);
        chk("reset_stall", 64'(stall), 64'(0));

        // Unsigned divide, then the plan constants.
        do_div("divu_100_7", 3'b011, 32'd100, 32'd7);
        chk("divu_100_7_const", {hi, lo}, {32'd2, 32'd14});

        // Signed divides including the overflow corner.
        do_div("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div("div_min_m1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_min_m1_const", {hi, lo}, {32'h0, 32'h8000_0000});
        do_div("div_7_m2", 3'b010, 32'd7, 32'hFFFF_FFFE);
        do_div("divu_max_3", 3'b011, 32'hFFFF_FFFF, 32'd3);

        // Divide by zero with preloaded HI/LO.
        do_simple("mthi_11", 3'b100, 32'h11, 32'h0);
        do_simple("mtlo_22", 3'b101, 32'h22, 32'h0);
        do_div("divu_by0", 3'b011, 32'd5, 32'd0);
        chk("divu_by0_const", {hi, lo}, {32'h11, 32'h22});

        // Back-to-back multiplies.
        do_simple("mult_m3_5", 3'b000, 32'hFFFF_FFFD, 32'd5);
        chk("mult_m3_5_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        do_simple("multu_max_2", 3'b001, 32'hFFFF_FFFF, 32'd2);
        chk("multu_max_2_const", {hi, lo}, {32'h1, 32'hFFFF_FFFE});
        do_simple("mult_min_min", 3'b000, 32'h8000_0000, 32'h8000_0000);

        // MTHI/MTLO with ignored 11x ops interleaved.
        do_simple("mthi_a5", 3'b100, 32'hA5A5_A5A5, 32'h0);
        do_simple("op110", 3'b110, 32'hDEAD_BEEF, 32'h1234_5678);
        do_simple("mtlo_5a", 3'b101, 32'h5A5A_5A5A, 32'h0);
        do_simple("op111", 3'b111, 32'hCAFE_F00D, 32'h0);
        chk("mtxx_const", {hi, lo}, {32'hA5A5_A5A5, 32'h5A5A_5A5A});

        // Reset in RUN cycle 10 with preloaded HI/LO, then restart.
        do_simple("mthi_pre", 3'b100, 32'h3333_3333, 32'h0);
        do_simple("mtlo_pre", 3'b101, 32'h4444_4444, 32'h0);
        op_valid = 1'b1; op = 3'b011; rs = 32'd100; rt = 32'd7;
        repeat (10) step();
        chk("rst_mid_busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_hilo", {hi, lo}, 64'h0);
        chk("rst_mid_restart_stall", 64'(stall), 64'(1));
        m_hi = '0; m_lo = '0;
        do_div("divu_restart", 3'b011, 32'd100, 32'd7);
        chk("divu_restart_const", {hi, lo}, {32'd2, 32'd14});

        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
